// File: rtl/dmem_pkg.sv
// Shared types and RV32I width codes for the data-memory controller.
// Optional feature: DMEM_MISALIGN_TRAP_EN (reject misaligned H/W accesses).
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    RMW_RD,
    RMW_MRG,
    WR,
    FIN
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Low two funct3 bits give the access size for both signed and unsigned codes.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (f3[1:0] == 2'b01) m = lo[0];
    if (f3[1:0] == 2'b10) m = (lo != 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension for RV32I loads.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store initiator for the single-port word RAM, with read-modify-write for SB/SH.
// Optional feature: DMEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dmem_state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_q;
  logic [31:0]       aligned;
  logic              req_any;
  logic              legal;
  logic              reject;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_W];

  function automatic logic [31:0] merge_sub(input logic [31:0] word, input logic [31:0] sd,
                                            input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (f3)
      F3_B: r[{lane, 3'b000} +: 8] = sd[7:0];
      F3_H: if (lane[1]) r[31:16] = sd[15:0]; else r[15:0] = sd[15:0];
      default: r = sd;
    endcase
    return r;
  endfunction

  assign req_any = req_load | req_store;

  // A simultaneous load and store is judged as the load, which wins.
  always_comb begin
    if (req_load) legal = (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else          legal = (funct3 inside {F3_B, F3_H, F3_W});
`ifdef DMEM_MISALIGN_TRAP_EN
    reject = !legal || misaligned(funct3, addr[1:0]);
`else
    reject = !legal;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (reject)           state_nx = FIN;
          else if (req_load)    state_nx = RD;
          else if (funct3 == F3_W) state_nx = WR;
          else                  state_nx = RMW_RD;
        end
      end
      RD:      state_nx = RD_CAP;
      RD_CAP:  state_nx = FIN;
      RMW_RD:  state_nx = RMW_MRG;
      RMW_MRG: state_nx = WR;
      WR:      state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state  <= IDLE;
      addr_q <= '0;
      f3_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_any) begin
        addr_q <= addr[ADDR_W-1:0];
        f3_q   <= funct3;
        err_q  <= reject;
      end
    end
  end

  load_align u_load_align (
    .word   (mem_rdata),
    .lane   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (aligned)
  );

  // Capture stage: extended load result and merged store word.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      if (state == IDLE && req_any && !req_load && !reject) wdata_q <= store_data;
      if (state == RMW_MRG) wdata_q <= merge_sub(mem_rdata, wdata_q, f3_q, addr_q[1:0]);
      if (state == RD_CAP)  load_q  <= aligned;
    end
  end

  assign mem_read_enable  = (state == RD) || (state == RMW_RD);
  assign mem_write_enable = (state == WR);
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign load_data        = load_q;
  assign busy             = (state != IDLE);
  assign done             = (state == FIN);
  assign err              = (state == FIN) && err_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Core-side initiator for the single-port word RAM's data port. Accepts one load or store per transaction from the execute stage and drives the RAM's `read_enable`, `write_enable`, byte address and write data. Performs RV32I sub-word handling: byte-lane extraction with sign or zero extension for loads, and read-modify-write for SB/SH, because the RAM only writes whole words. Holds the core stalled via `busy` until a one-cycle `done` pulse.

## Interface
- `ADDR_W`, default 6: byte-address width driven to the RAM; the RAM indexes words with `addr>>2`.
- `clk` in 1: clock.
- `nRst` in 1: reset, asynchronous, active-low.
- `req_load` in 1: load request, sampled in IDLE only.
- `req_store` in 1: store request, sampled in IDLE only.
- `funct3` in 3: RV32I width code. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- `addr` in 32: byte address from the ALU.
- `store_data` in 32: rs2 value.
- `mem_rdata` in 32: RAM `data_out`, registered in the RAM, valid one cycle after the address is presented.
- `mem_read_enable` out 1: to RAM `read_enable`.
- `mem_write_enable` out 1: to RAM `write_enable`.
- `mem_addr` out ADDR_W: to RAM `address_DM`, equal to `addr[ADDR_W-1:0]` latched at accept.
- `mem_wdata` out 32: to RAM `data_in`.
- `load_data` out 32: extended load result, held until the next completed load.
- `busy` out 1: high in every state except IDLE; the core freezes the PC while it is high.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `done` for a rejected request.

## Operation
- States: IDLE, RD, RD_CAP, RMW_RD, RMW_MRG, WR, FIN.
- IDLE: on `req_load` latch `addr`, `funct3` and `store_data`, then go to RD. On `req_store` latch the same and go to WR if SW, otherwise RMW_RD. If both requests are high, the load wins. An illegal `funct3` goes to FIN with `err` set and makes no memory access.
- RD: `mem_read_enable=1`, then go to RD_CAP.
- RD_CAP: `mem_rdata` is valid. Select the lane with `addr[1:0]` for bytes and `addr[1]` for halves, extend it (LB/LH sign-extend, LBU/LHU zero-extend, LW passes through) and register the result into `load_data`. Then go to FIN.
- RMW_RD: `mem_read_enable=1`, then go to RMW_MRG.
- RMW_MRG: replace the addressed byte or half of `mem_rdata` with `store_data[7:0]` or `store_data[15:0]` and register the result into `mem_wdata`. Then go to WR.
- WR: `mem_write_enable=1`, with `mem_wdata` set to the merged word, or to `store_data` for SW. Then go to FIN.
- FIN: `done=1`, then go to IDLE.
- `mem_addr` stays stable from accept until IDLE. Both enables are 0 in every other state.
- Requests raised while `busy` is high are ignored. The core holds a request at most until `done`; if it is still high in the following IDLE cycle, it is accepted again.

## Timing
- Reset values: state IDLE; `mem_read_enable`, `mem_write_enable`, `busy`, `done` and `err` 0; `mem_addr`, `mem_wdata` and `load_data` 0.
- Load: accepted at edge 0; RD in cycle 1; RD_CAP in cycle 2; `done` in cycle 3 with `load_data` valid from that cycle.
- SW: accepted at edge 0; WR in cycle 1; `done` in cycle 2.
- SB/SH: accepted at edge 0; RMW_RD in cycle 1; RMW_MRG in cycle 2; WR in cycle 3; `done` in cycle 4.
- Rejected request: `done` and `err` in cycle 1.
- Back-to-back: the earliest next accept is the cycle after FIN.
- Reset asserted mid-transaction: returns to IDLE asynchronously and drops the enables at once. An RMW interrupted before WR writes nothing, and `load_data` clears to 0.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: misaligned accesses are rejected (FIN with `err`, no memory access). Misaligned means H with `addr[0]=1`, or W with `addr[1:0]!=0`.
- `DMEM_MISALIGN_TRAP_EN` undefined: misalignment is never flagged. W accesses ignore `addr[1:0]`; H accesses ignore `addr[0]`; the transaction proceeds normally.

## Structure
- Package `dmem_pkg` holds the state enum `dmem_state_t` and the funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `load_align` is purely combinational: inputs word, `addr[1:0]` and `funct3`; output extended data. It feeds the RD_CAP register.

## Test plan
- LW, `addr=0x0C`, RAM word 3 = `0xDEADBEEF`: `done` in cycle 3, `load_data=0xDEADBEEF`, `mem_read_enable` high in cycle 1 only.
- LB, `addr=0x0D`, word `0x1234F0AB`: `load_data=0xFFFFFFF0`. LBU at the same address: `load_data=0x000000F0`.
- SB, `addr=0x06`, `store_data=0xAA`, word 1 = `0x11223344`: write in cycle 3 with `mem_wdata=0x11AA3344`, `done` in cycle 4.
- SH, `addr=0x02`, `store_data=0xBEEF`, word 0 = `0x00000000`: writes `0xBEEF0000`. A following LHU at `0x02` returns `0x0000BEEF`.
- LW at `addr=0x05` with `DMEM_MISALIGN_TRAP_EN` defined: `done` and `err` in cycle 1, no enables. Without the macro: reads word 1 and `err` stays 0.
- SB, with `nRst` pulsed low during RMW_MRG: no `mem_write_enable`, the RAM word is unchanged, `busy` returns to 0, and a following SW completes normally.
